// File: rtl/axi_write_stager.sv
// Write-job stager: buffers core result words in a FIFO, issues one INCR write request and
// streams the words to the AXI write master. Optional stall counter: AXI_WRITE_STAGER_PERF_EN.
module axi_write_stager #(
    parameter int AXI_AWIDTH = 32,
    parameter int AXI_DWIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [AXI_AWIDTH-1:0] job_addr,
    input  logic [31:0]           job_len,
    input  logic [AXI_DWIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  core_write_request_valid,
    input  logic                  core_write_request_ready,
    output logic [AXI_AWIDTH-1:0] core_write_addr,
    output logic [31:0]           core_write_len,
    output logic [2:0]            core_write_size,
    output logic [1:0]            core_write_burst,
    output logic [AXI_DWIDTH-1:0] core_write_data,
    output logic                  core_write_data_valid,
    input  logic                  core_write_data_ready,
    output logic                  busy,
    output logic                  done
`ifdef AXI_WRITE_STAGER_PERF_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_DONE} state_t;

    state_t                r_state, w_next;
    logic [AXI_AWIDTH-1:0] r_addr;
    logic [31:0]           r_len, r_len_m1, r_in_cnt, r_out_cnt;
    logic [PW:0]           r_wr_ptr, r_rd_ptr;
    logic [AXI_DWIDTH-1:0] r_mem [FIFO_DEPTH];

    logic w_full, w_empty, w_job_fire, w_in_fire, w_out_fire, w_req_fire, w_last;

    // Extra pointer MSB separates full from empty when the index bits match.
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_job_fire = job_valid & job_ready;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = core_write_data_valid & core_write_data_ready;
    assign w_req_fire = core_write_request_valid & core_write_request_ready;
    assign w_last     = (r_out_cnt == r_len_m1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_job_fire) w_next = (job_len == 32'd0) ? S_DONE : S_REQ;
            S_REQ:  if (w_req_fire) w_next = S_DATA;
            S_DATA: if (w_out_fire && w_last) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // job_ready is masked by rst so every handshake output is low while reset is held.
    always_comb begin
        job_ready                = (r_state == S_IDLE) & ~rst;
        core_write_request_valid = (r_state == S_REQ);
        in_ready                 = ((r_state == S_REQ) || (r_state == S_DATA)) && !w_full &&
                                   (r_in_cnt < r_len);
        core_write_data_valid    = (r_state == S_DATA) && !w_empty;
        busy                     = (r_state != S_IDLE);
        done                     = (r_state == S_DONE);
    end

    assign core_write_addr  = r_addr;
    assign core_write_len   = r_len_m1;
    assign core_write_size  = 3'($clog2(AXI_DWIDTH / 8));
    assign core_write_burst = 2'b01;
    assign core_write_data  = r_mem[r_rd_ptr[PW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr    <= '0;
            r_len     <= '0;
            r_len_m1  <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
        end else if (w_job_fire) begin
            r_addr    <= job_addr;
            r_len     <= job_len;
            r_len_m1  <= job_len - 32'd1;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_rd_ptr  <= r_wr_ptr;
        end else begin
            if (w_in_fire) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_in_cnt <= r_in_cnt + 32'd1;
            end
            if (w_out_fire) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_out_cnt <= r_out_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_fire) r_mem[r_wr_ptr[PW-1:0]] <= in_data;
    end

`ifdef AXI_WRITE_STAGER_PERF_EN
    logic [31:0] r_stall;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                r_stall <= '0;
        else if (w_job_fire)    r_stall <= '0;
        else if (core_write_data_valid && !core_write_data_ready && r_stall != 32'hFFFF_FFFF)
            r_stall <= r_stall + 32'd1;
    end
    assign stall_cycles = r_stall;
`endif
endmodule
